axi_lite_regbank: RTL and testbench
===================================

# axi_lite_regbank

Parametrised AXI4-Lite slave register bank: decodes AXI4-Lite write/read transactions into an array of `NUM_REGS` registers with byte-strobe writes, read-only masking and SLVERR on illegal accesses. It sits between the AXI4-Lite bus and peripheral cores (UART first), exporting register contents and per-register write pulses and importing status values for read-only registers.

## Interface
- `ADDR_WIDTH`, 6: AXI address width (byte address).
- `DATA_WIDTH`, 32: data width; 32 or 64 only.
- `NUM_REGS`, 8: number of registers; 1 to 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- `RO_MASK`, 0: `NUM_REGS`-bit mask; bit i=1 makes register i read-only (value taken from `reg_in`).
- `ACLK` in 1: clock.
- `ARESET` in 1: synchronous, active-high reset.
- `AWADDR` in ADDR_WIDTH, `AWVALID` in 1, `AWREADY` out 1: write address channel.
- `WDATA` in DATA_WIDTH, `WSTRB` in DATA_WIDTH/8, `WVALID` in 1, `WREADY` out 1: write data channel.
- `BRESP` out 2, `BVALID` out 1, `BREADY` in 1: write response channel.
- `ARADDR` in ADDR_WIDTH, `ARVALID` in 1, `ARREADY` out 1: read address channel.
- `RDATA` out DATA_WIDTH, `RRESP` out 2, `RVALID` out 1, `RREADY` in 1: read data channel.
- `reg_out` out NUM_REGS*DATA_WIDTH: current RW register contents, register i at slice i.
- `reg_in` in NUM_REGS*DATA_WIDTH: values returned for RO registers.
- `wr_pulse` out NUM_REGS: one-cycle pulse on the cycle register i is updated.

## Operation
- Word index = address >> log2(DATA_WIDTH/8); low address bits ignored.
- Write path: AW and W accepted independently, each into a one-entry holding register. `AWREADY` = !aw_held && !BVALID; `WREADY` = !w_held && !BVALID.
- Commit when address and data both available (held, or handshaking this cycle): index < NUM_REGS and RO_MASK bit clear → bytes with WSTRB=1 updated, others kept, `wr_pulse[i]`=1, BRESP=OKAY (2'b00). Index out of range or RO → no update, no pulse, BRESP=SLVERR (2'b10).
- BVALID holds with stable BRESP until BREADY; holding registers clear at commit.
- WSTRB=0 to a valid RW register: no byte change, `wr_pulse` still fires, OKAY.
- Read path: `ARREADY` = !RVALID. On AR handshake, RDATA is registered: RO register → `reg_in` slice, RW → stored value, out of range → 0 with RRESP=SLVERR. RVALID/RDATA/RRESP stable until RREADY.
- Read and write to the same register committing in the same cycle: read returns the pre-write value.
- Read and write channels fully independent; no ordering between them.

## Timing
- Reset: AWREADY=0, WREADY=0, BVALID=0, BRESP=0, ARREADY=0, RVALID=0, RDATA=0, RRESP=0, all registers 0, `wr_pulse`=0, holding registers empty. READY outputs go high the first cycle after ARESET deasserts.
- AW and W handshake in cycle N → register, `wr_pulse` and BVALID all visible at N+1. With BREADY=1 at N+1, AWREADY/WREADY rise at N+2: max one write per 2 cycles.
- AW at N, W at N+k → commit at N+k, BVALID at N+k+1.
- AR handshake at N → RVALID at N+1; with RREADY=1, ARREADY rises at N+2.
- ARESET mid-transaction: pending holding registers, BVALID and RVALID dropped next cycle; no response issued.

## Structure
- Package `axi_lite_pkg`: `axi_resp_t` enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11), strobe-merge function.
- One sub-module: `axi_lite_wr_ctrl` (AW/W holding, commit and B-channel logic); read path and register array stay in the top.

## Test plan
- Reset then write 0xDEADBEEF to addr 0x4 with AW/W same cycle, WSTRB=4'hF → BVALID next cycle, OKAY; `reg_out` reg1=0xDEADBEEF; `wr_pulse`=8'h02 for one cycle.
- W at cycle 0, AW at cycle 3 to addr 0x0, WSTRB=4'b0101, data 0x11223344 over 0xAABBCCDD → reg0=0xAA22CC44, BVALID at cycle 4.
- RO_MASK=8'h80, `reg_in` reg7=0x12345678: write to 0x1C → SLVERR, no pulse; read 0x1C → 0x12345678, OKAY.
- NUM_REGS=8, read addr 0x20 and write addr 0x24 → both SLVERR, RDATA=0, no register change.
- Hold BREADY/RREADY low 5 cycles → BVALID/RVALID and payloads stable, AWREADY/WREADY/ARREADY low throughout.
- Assert ARESET while BVALID pending → BVALID=0 next cycle, all registers 0.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
// Holds the response encoding and the byte-strobe merge used on register writes.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    localparam int unsigned MaxDataWidth = 64;
    localparam int unsigned MaxStrbWidth = MaxDataWidth / 8;

    // Callers zero-extend narrower words and truncate the result back to their width.
    function automatic logic [MaxDataWidth-1:0] strb_merge(
        input logic [MaxDataWidth-1:0] old_data,
        input logic [MaxDataWidth-1:0] new_data,
        input logic [MaxStrbWidth-1:0] strb
    );
        logic [MaxDataWidth-1:0] merged;
        merged = old_data;
        for (int b = 0; b < MaxStrbWidth; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_data[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_wr_ctrl.sv
// AXI4-Lite write channel control: independent AW/W holding slots, commit decode
// and the B channel. Emits per-register write selects for the register array.
module axi_lite_wr_ctrl
    import axi_lite_pkg::*;
#(
    parameter int unsigned         ADDR_WIDTH = 6,
    parameter int unsigned         DATA_WIDTH = 32,
    parameter int unsigned         NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    output logic [NUM_REGS-1:0]     wr_sel_o,
    output logic [DATA_WIDTH-1:0]   wr_data_o,
    output logic [DATA_WIDTH/8-1:0] wr_strb_o,
    output logic [NUM_REGS-1:0]     wr_pulse_o
);

    localparam int unsigned StrbWidth = DATA_WIDTH / 8;
    localparam int unsigned AddrLsb   = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = ADDR_WIDTH - AddrLsb;

    logic                  en_q;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [IdxWidth-1:0]   aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [StrbWidth-1:0]  wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    axi_resp_t             bresp_q, bresp_d;
    logic [NUM_REGS-1:0]   wr_pulse_q;

    logic                  aw_hs, w_hs, commit;
    logic [IdxWidth-1:0]   cur_idx;
    logic [NUM_REGS-1:0]   hit;
    logic                  unused_awaddr_lsb;

    assign unused_awaddr_lsb = ^awaddr_i[AddrLsb-1:0];

    // en_q keeps every READY low until the first cycle after reset is released.
    assign awready_o = en_q && !aw_held_q && !bvalid_q;
    assign wready_o  = en_q && !w_held_q && !bvalid_q;
    assign aw_hs     = awvalid_i && awready_o;
    assign w_hs      = wvalid_i && wready_o;
    assign commit    = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;

    assign cur_idx   = aw_held_q ? aw_idx_q : awaddr_i[ADDR_WIDTH-1:AddrLsb];
    assign wr_data_o = w_held_q ? wdata_q : wdata_i;
    assign wr_strb_o = w_held_q ? wstrb_q : wstrb_i;

    // Out-of-range indices match no entry, so they fall out as SLVERR.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            hit[i] = (int'(cur_idx) == i) && !RO_MASK[i];
        end
    end

    assign wr_sel_o = commit ? hit : '0;

    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = awaddr_i[ADDR_WIDTH-1:AddrLsb];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = wdata_i;
            wstrb_d  = wstrb_i;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (|hit) ? OKAY : SLVERR;
        end else if (bvalid_q && bready_i) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q       <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            wr_pulse_q <= '0;
        end else begin
            en_q       <= 1'b1;
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_sel_o;
        end
    end

    assign bvalid_o   = bvalid_q;
    assign bresp_o    = bresp_q;
    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: byte-strobed RW registers, read-only status
// registers fed from reg_in, and SLVERR on out-of-range or read-only writes.
module axi_lite_regbank
    import axi_lite_pkg::*;
#(
    parameter int unsigned         ADDR_WIDTH = 6,
    parameter int unsigned         DATA_WIDTH = 32,
    parameter int unsigned         NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int unsigned StrbWidth = DATA_WIDTH / 8;
    localparam int unsigned AddrLsb   = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = ADDR_WIDTH - AddrLsb;
    localparam int unsigned BankWidth = NUM_REGS * DATA_WIDTH;

    logic [NUM_REGS-1:0]   wr_sel;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [StrbWidth-1:0]  wr_strb;
    logic [BankWidth-1:0]  regs_q, regs_d;

    axi_lite_wr_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK)
    ) u_wr_ctrl (
        .clk_i      (ACLK),
        .rst_i      (ARESET),
        .awaddr_i   (AWADDR),
        .awvalid_i  (AWVALID),
        .awready_o  (AWREADY),
        .wdata_i    (WDATA),
        .wstrb_i    (WSTRB),
        .wvalid_i   (WVALID),
        .wready_o   (WREADY),
        .bresp_o    (BRESP),
        .bvalid_o   (BVALID),
        .bready_i   (BREADY),
        .wr_sel_o   (wr_sel),
        .wr_data_o  (wr_data),
        .wr_strb_o  (wr_strb),
        .wr_pulse_o (wr_pulse)
    );

    // Read-only slots are never selected, so their storage stays at zero.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_sel[i]) begin
                regs_d[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(strb_merge(
                    MaxDataWidth'(regs_q[i*DATA_WIDTH +: DATA_WIDTH]),
                    MaxDataWidth'(wr_data),
                    MaxStrbWidth'(wr_strb)));
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign reg_out = regs_q;

    logic                  rd_en_q;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_lookup;
    axi_resp_t             rresp_q, rresp_d, rd_resp;
    logic [IdxWidth-1:0]   ar_idx;
    logic                  ar_hs;
    logic                  unused_araddr_lsb;

    assign unused_araddr_lsb = ^ARADDR[AddrLsb-1:0];
    assign ar_idx            = ARADDR[ADDR_WIDTH-1:AddrLsb];
    assign ARREADY           = rd_en_q && !rvalid_q;
    assign ar_hs             = ARVALID && ARREADY;

    // Reads sample regs_q, so a same-cycle write is not yet visible.
    always_comb begin
        rd_lookup = '0;
        rd_resp   = SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(ar_idx) == i) begin
                rd_resp   = OKAY;
                rd_lookup = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH]
                                       : regs_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_lookup;
            rresp_d  = rd_resp;
        end else if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_en_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
        end else begin
            rd_en_q  <= 1'b1;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    assign RVALID = rvalid_q;
    assign RDATA  = rdata_q;
    assign RRESP  = rresp_q;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank: directed scenarios plus randomized
// traffic checked against a word/byte-level model of the register bank.
module tb_axi_lite_regbank;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 8;
    localparam logic [NR-1:0] RO = 8'h80;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic [AW-1:0] awaddr = '0;
    logic awvalid = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic wvalid = 1'b0;
    logic bready = 1'b0;
    logic [AW-1:0] araddr = '0;
    logic arvalid = 1'b0;
    logic rready = 1'b0;
    logic [NR*DW-1:0] reg_in = '0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [DW-1:0] rdata;
    logic [NR*DW-1:0] reg_out;
    logic [NR-1:0] wr_pulse;

    axi_lite_regbank #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .RO_MASK    (RO)
    ) dut (
        .ACLK     (aclk),
        .ARESET   (areset),
        .AWADDR   (awaddr),
        .AWVALID  (awvalid),
        .AWREADY  (awready),
        .WDATA    (wdata),
        .WSTRB    (wstrb),
        .WVALID   (wvalid),
        .WREADY   (wready),
        .BRESP    (bresp),
        .BVALID   (bvalid),
        .BREADY   (bready),
        .ARADDR   (araddr),
        .ARVALID  (arvalid),
        .ARREADY  (arready),
        .RDATA    (rdata),
        .RRESP    (rresp),
        .RVALID   (rvalid),
        .RREADY   (rready),
        .reg_out  (reg_out),
        .reg_in   (reg_in),
        .wr_pulse (wr_pulse)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [DW-1:0] model [NR];

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int k = 0; k < NR; k++) f[k*DW +: DW] = model[k];
        return f;
    endfunction

    // Full write transaction; resp stays X if no response arrives within the budget.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output logic [NR-1:0] pulses);
        bit aw_done = 0;
        bit w_done = 0;
        bit b_done = 0;
        int cyc = 0;
        resp = 'x;
        pulses = '0;
        bready = 1'b1;
        awaddr = a;
        wdata = d;
        wstrb = s;
        while (!b_done && cyc < 50) begin
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid = !w_done && cyc >= w_dly;
            @(negedge aclk);
            pulses |= wr_pulse;
            if (bvalid) begin
                resp = bresp;
                b_done = 1;
            end
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            @(posedge aclk);
            #1;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid = 1'b0;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                           output logic [1:0] resp);
        bit ar_done = 0;
        bit r_done = 0;
        int cyc = 0;
        d = 'x;
        resp = 'x;
        rready = 1'b1;
        araddr = a;
        while (!r_done && cyc < 50) begin
            arvalid = !ar_done;
            @(negedge aclk);
            if (rvalid) begin
                d = rdata;
                resp = rresp;
                r_done = 1;
            end
            if (arvalid && arready) ar_done = 1;
            @(posedge aclk);
            #1;
            cyc++;
        end
        arvalid = 1'b0;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_cmp++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin n_fail++;
            $display("FAIL reset_ctrl: got %b, want 00000",
                     {awready, wready, arready, bvalid, rvalid}); end
        n_cmp++; if ({bresp, rresp, rdata} !== 36'h0) begin n_fail++;
            $display("FAIL reset_payload: got bresp=%b rresp=%b rdata=%h, want zeros",
                     bresp, rresp, rdata); end
        n_cmp++; if ({reg_out, wr_pulse} !== '0) begin n_fail++;
            $display("FAIL reset_regs: got reg_out=%h pulse=%h, want 0", reg_out, wr_pulse); end
        @(posedge aclk); #1 areset = 1'b0;
        @(posedge aclk); #1;
        @(negedge aclk);
        n_cmp++; if ({awready, wready, arready} !== 3'b111) begin n_fail++;
            $display("FAIL reset_release: got %b, want 111", {awready, wready, arready}); end
        @(posedge aclk); #1;
        for (int k = 0; k < NR; k++) model[k] = '0;
    endtask

    task automatic test_basic_write();
        awaddr = 6'h04; awvalid = 1'b1;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(negedge aclk);
        n_cmp++; if ({awready, wready} !== 2'b11) begin n_fail++;
            $display("FAIL basic_hs: got %b, want 11", {awready, wready}); end
        @(posedge aclk); #1 awvalid = 1'b0; wvalid = 1'b0;
        @(negedge aclk);
        n_cmp++; if ({bvalid, bresp} !== 3'b100) begin n_fail++;
            $display("FAIL basic_b: got %b, want 100", {bvalid, bresp}); end
        n_cmp++; if (reg_out[63:32] !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL basic_reg1: got %h, want deadbeef", reg_out[63:32]); end
        n_cmp++; if (wr_pulse !== 8'h02) begin n_fail++;
            $display("FAIL basic_pulse: got %h, want 02", wr_pulse); end
        n_cmp++; if ({awready, wready} !== 2'b00) begin n_fail++;
            $display("FAIL basic_busy: got %b, want 00", {awready, wready}); end
        bready = 1'b1;
        @(posedge aclk); #1 bready = 1'b0;
        @(negedge aclk);
        n_cmp++; if ({bvalid, wr_pulse, awready, wready} !== 11'b0_00000000_11) begin n_fail++;
            $display("FAIL basic_after: got bvalid=%b pulse=%h rdy=%b, want 0/00/11",
                     bvalid, wr_pulse, {awready, wready}); end
        @(posedge aclk); #1;
        model[1] = 32'hDEADBEEF;
    endtask

    task automatic test_split_write();
        logic [1:0] r;
        logic [NR-1:0] p;
        do_write(6'h00, 32'hAABBCCDD, 4'hF, 0, 0, r, p);
        model[0] = 32'hAABBCCDD;
        n_cmp++; if (r !== 2'b00) begin n_fail++;
            $display("FAIL split_pre: got %b, want 00", r); end
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        @(negedge aclk);
        n_cmp++; if (wready !== 1'b1) begin n_fail++;
            $display("FAIL split_wready: got %b, want 1", wready); end
        @(posedge aclk); #1 wvalid = 1'b0;
        for (int c = 1; c < 3; c++) begin
            @(negedge aclk);
            n_cmp++; if ({bvalid, wready, wr_pulse} !== 10'b0) begin n_fail++;
                $display("FAIL split_wait%0d: got bvalid=%b wready=%b pulse=%h, want 0",
                         c, bvalid, wready, wr_pulse); end
            @(posedge aclk); #1;
        end
        awaddr = 6'h00; awvalid = 1'b1;
        @(negedge aclk);
        n_cmp++; if ({awready, bvalid} !== 2'b10) begin n_fail++;
            $display("FAIL split_aw: got %b, want 10", {awready, bvalid}); end
        @(posedge aclk); #1 awvalid = 1'b0;
        @(negedge aclk);
        n_cmp++; if ({bvalid, bresp, wr_pulse} !== 11'b100_00000001) begin n_fail++;
            $display("FAIL split_b: got bvalid=%b bresp=%b pulse=%h, want 1/00/01",
                     bvalid, bresp, wr_pulse); end
        n_cmp++; if (reg_out[31:0] !== 32'hAA22CC44) begin n_fail++;
            $display("FAIL split_reg0: got %h, want aa22cc44", reg_out[31:0]); end
        bready = 1'b1;
        @(posedge aclk); #1 bready = 1'b0;
        model[0] = 32'hAA22CC44;
    endtask

    task automatic test_ro_and_range();
        logic [1:0] r;
        logic [NR-1:0] p;
        logic [DW-1:0] d;
        for (int k = 0; k < NR; k++) reg_in[k*DW +: DW] = $urandom;
        reg_in[7*DW +: DW] = 32'h12345678;
        do_write(6'h1C, $urandom, 4'hF, 0, 0, r, p);
        n_cmp++; if ({r, p} !== 10'b10_00000000) begin n_fail++;
            $display("FAIL ro_write: got resp=%b pulse=%h, want 10/00", r, p); end
        do_read(6'h1C, d, r);
        n_cmp++; if ({d, r} !== {32'h12345678, 2'b00}) begin n_fail++;
            $display("FAIL ro_read: got data=%h resp=%b, want 12345678/00", d, r); end
        do_read(6'h20, d, r);
        n_cmp++; if ({d, r} !== {32'h0, 2'b10}) begin n_fail++;
            $display("FAIL oob_read: got data=%h resp=%b, want 0/10", d, r); end
        do_write(6'h24, $urandom, 4'hF, 0, 0, r, p);
        n_cmp++; if ({r, p} !== 10'b10_00000000) begin n_fail++;
            $display("FAIL oob_write: got resp=%b pulse=%h, want 10/00", r, p); end
        n_cmp++; if (reg_out !== model_flat()) begin n_fail++;
            $display("FAIL oob_regs: got %h, want %h", reg_out, model_flat()); end
    endtask

    task automatic test_same_cycle();
        logic [DW-1:0] old_v, new_v;
        old_v = model[2];
        new_v = $urandom;
        awaddr = 6'h08; awvalid = 1'b1; wdata = new_v; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 6'h0B; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        @(negedge aclk);
        n_cmp++; if ({awready, wready, arready} !== 3'b111) begin n_fail++;
            $display("FAIL same_hs: got %b, want 111", {awready, wready, arready}); end
        @(posedge aclk); #1 awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge aclk);
        n_cmp++; if ({rvalid, rdata, rresp} !== {1'b1, old_v, 2'b00}) begin n_fail++;
            $display("FAIL same_read: got v=%b data=%h resp=%b, want 1/%h/00",
                     rvalid, rdata, rresp, old_v); end
        n_cmp++; if ({bvalid, reg_out[95:64]} !== {1'b1, new_v}) begin n_fail++;
            $display("FAIL same_write: got bvalid=%b reg2=%h, want 1/%h",
                     bvalid, reg_out[95:64], new_v); end
        rready = 1'b1; bready = 1'b1;
        @(posedge aclk); #1 rready = 1'b0; bready = 1'b0;
        model[2] = new_v;
    endtask

    task automatic test_stall();
        logic [DW-1:0] d3;
        d3 = $urandom;
        awaddr = 6'h0C; awvalid = 1'b1; wdata = d3; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 6'h08; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        @(posedge aclk); #1;
        // Keep offering new requests; none may be accepted while responses are pending.
        awaddr = 6'h10; wdata = ~d3; araddr = 6'h14;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            n_cmp++; if ({bvalid, bresp, rvalid, rdata, rresp} !== {3'b100, 1'b1, model[2], 2'b00})
                begin n_fail++;
                $display("FAIL stall_resp%0d: got b=%b/%b r=%b/%h/%b, want 1/00 1/%h/00", c,
                         bvalid, bresp, rvalid, rdata, rresp, model[2]); end
            n_cmp++; if ({awready, wready, arready} !== 3'b000) begin n_fail++;
                $display("FAIL stall_ready%0d: got %b, want 000", c, {awready, wready, arready}); end
            @(posedge aclk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        @(posedge aclk); #1 bready = 1'b0; rready = 1'b0;
        model[3] = d3;
        @(negedge aclk);
        n_cmp++; if ({bvalid, rvalid, reg_out} !== {2'b00, model_flat()}) begin n_fail++;
            $display("FAIL stall_after: got b=%b r=%b regs=%h, want 0/0/%h",
                     bvalid, rvalid, reg_out, model_flat()); end
        @(posedge aclk); #1;
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [DW-1:0] d, got_d, exp_d;
        logic [3:0] s;
        logic [1:0] r, exp_r;
        logic [NR-1:0] p, exp_p, ro_mask;
        int idx;
        ro_mask = RO;
        for (int it = 0; it < 80; it++) begin
            for (int k = 0; k < NR; k++) reg_in[k*DW +: DW] = $urandom;
            a = AW'($urandom_range(0, 63));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            idx = int'(a) / 4;
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), r, p);
                if (idx < NR && !ro_mask[idx]) begin
                    for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
                    exp_r = 2'b00;
                    exp_p = NR'(1) << idx;
                end else begin
                    exp_r = 2'b10;
                    exp_p = '0;
                end
                n_cmp++; if ({r, p} !== {exp_r, exp_p}) begin n_fail++;
                    $display("FAIL rand_wr%0d a=%h: got resp=%b pulse=%h, want %b/%h",
                             it, a, r, p, exp_r, exp_p); end
            end else begin
                do_read(a, got_d, r);
                if (idx >= NR) begin
                    exp_d = '0; exp_r = 2'b10;
                end else begin
                    exp_d = ro_mask[idx] ? reg_in[idx*DW +: DW] : model[idx];
                    exp_r = 2'b00;
                end
                n_cmp++; if ({got_d, r} !== {exp_d, exp_r}) begin n_fail++;
                    $display("FAIL rand_rd%0d a=%h: got %h/%b, want %h/%b",
                             it, a, got_d, r, exp_d, exp_r); end
            end
            n_cmp++; if (reg_out !== model_flat()) begin n_fail++;
                $display("FAIL rand_regs%0d: got %h, want %h", it, reg_out, model_flat()); end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r;
        logic [NR-1:0] p;
        logic [DW-1:0] d6;
        bit seen_b;
        awaddr = 6'h14; awvalid = 1'b1; wdata = $urandom; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 6'h04; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        @(posedge aclk); #1 awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; areset = 1'b1;
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        n_cmp++; if ({bvalid, rvalid, wr_pulse} !== 10'b0) begin n_fail++;
            $display("FAIL midrst_ctrl: got b=%b r=%b pulse=%h, want 0", bvalid, rvalid, wr_pulse); end
        n_cmp++; if (reg_out !== '0) begin n_fail++;
            $display("FAIL midrst_regs: got %h, want 0", reg_out); end
        @(posedge aclk); #1;
        for (int k = 0; k < NR; k++) model[k] = '0;
        // A held W beat must not survive reset and pair with a later AW.
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge aclk); #1 wvalid = 1'b0; areset = 1'b1;
        @(posedge aclk); #1 areset = 1'b0;
        @(posedge aclk); #1;
        awaddr = 6'h18; awvalid = 1'b1;
        @(posedge aclk); #1 awvalid = 1'b0;
        seen_b = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge aclk);
            if (bvalid) seen_b = 1;
            @(posedge aclk); #1;
        end
        n_cmp++; if (seen_b !== 1'b0) begin n_fail++;
            $display("FAIL midrst_held: got bvalid seen=%b, want 0", seen_b); end
        d6 = $urandom;
        do_write(6'h18, d6, 4'hF, 1000, 0, r, p);
        model[6] = d6;
        n_cmp++; if ({r, p, reg_out} !== {2'b00, 8'h40, model_flat()}) begin n_fail++;
            $display("FAIL midrst_resume: got resp=%b pulse=%h regs=%h, want 00/40/%h",
                     r, p, reg_out, model_flat()); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_write();
        test_split_write();
        test_ro_and_range();
        test_same_cycle();
        test_stall();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
